note_sequencer: RTL

Controller that sequences the tone/LED datapath through a song stored in an external synchronous ROM. It derives a 1 ms tick from the ticks_per_milli input. For each note it fetches the word, drives note_code and tone_en to the tone generator for the note's duration, then inserts a fixed silent gap. It sits between the top-level wrapper and the tone generator/LED driver, and replaces a free-running music loop with an addressable, restartable one.

---
 rtl/note_sequencer_pkg.sv | 26 ++
 rtl/note_sequencer_if.sv | 10 +
 rtl/note_sequencer_ms_ticker.sv | 31 +++
 rtl/note_sequencer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared types and constants for the note sequencer and its ms ticker.
package note_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [5:0] NOTE_REST = 6'd0;
   localparam logic [5:0] NOTE_END  = 6'd63;

   localparam int NOTE_MSB = 15;
   localparam int NOTE_LSB = 10;
   localparam int DUR_MSB  = 9;
   localparam int DUR_LSB  = 0;

   // One-hot LED pattern selected by the low three bits of a note code.
   function automatic logic [7:0] led_of(input logic [5:0] code);
      return 8'b1 << code[2:0];
   endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Song ROM bus: registered address out, synchronous data back one cycle later.
interface note_sequencer_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_data;

   modport master (output rom_addr, input  rom_data);
   modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/note_sequencer_ms_ticker.sv
// Millisecond tick generator: divides clk by max(ticks_per_milli,1).
module ms_ticker (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ticks_per_milli,
   input  logic        clr,
   output logic        ms_tick
);

   logic [15:0] tick_cnt;
   logic [15:0] tick_last;

   // Terminal count; a zero period behaves as one cycle per ms.
   always_comb begin
      tick_last = (ticks_per_milli == '0) ? '0 : ticks_per_milli - 16'd1;
   end

   assign ms_tick = (tick_cnt == tick_last);

   // Count up to the terminal value; an overshoot after a period change wraps at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (clr || tick_cnt >= tick_last) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// Walks a song ROM note by note, timing each note and the silent gap in ms.
module note_sequencer
   import note_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int GAP_MS = 20,
   parameter int LOOP   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [15:0]         ticks_per_milli,
   input  logic                enable,
   note_sequencer_if.master    rom,
   output logic [5:0]          note_code,
   output logic                tone_en,
   output logic                note_strobe,
   output logic [7:0]          led,
   output logic                song_done
);

   localparam logic [9:0] GAP_LAST = (GAP_MS > 0) ? 10'(GAP_MS - 1) : '0;

   state_t      state;
   logic [9:0]  dur;
   logic [9:0]  ms_cnt;
   logic        tick_clr;
   logic        ms_tick;
   logic        ms_last;
   logic [5:0]  word_code;
   logic [9:0]  word_dur;

   assign word_code = rom.rom_data[NOTE_MSB:NOTE_LSB];
   assign word_dur  = rom.rom_data[DUR_MSB:DUR_LSB];

   // Ticker runs only while timing a note or gap, so each starts on a full ms.
   always_comb begin
      tick_clr = !(state == S_PLAY || state == S_GAP);
   end

   // Last ms of the current timed phase.
   always_comb begin
      if (state == S_PLAY) begin
         ms_last = (ms_cnt == dur - 10'd1);
      end else begin
         ms_last = (ms_cnt == GAP_LAST);
      end
   end

   ms_ticker u_ticker (
      .clk             (clk),
      .rst             (rst),
      .ticks_per_milli (ticks_per_milli),
      .clr             (tick_clr),
      .ms_tick         (ms_tick)
   );

   // Sequencer FSM with registered outputs; enable low aborts from any state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         rom.rom_addr <= '0;
         note_code    <= NOTE_REST;
         tone_en      <= 1'b0;
         note_strobe  <= 1'b0;
         led          <= '0;
         song_done    <= 1'b0;
         dur          <= '0;
         ms_cnt       <= '0;
      end else begin
         note_strobe <= 1'b0;
         if (!enable) begin
            state        <= S_IDLE;
            rom.rom_addr <= '0;
            note_code    <= NOTE_REST;
            tone_en      <= 1'b0;
            led          <= '0;
            song_done    <= 1'b0;
            ms_cnt       <= '0;
         end else begin
            case (state)
               S_IDLE:  state <= S_FETCH;
               S_FETCH: state <= S_LOAD;
               S_LOAD: begin
                  if (word_code == NOTE_END) begin
                     if (LOOP != 0) begin
                        rom.rom_addr <= '0;
                        state        <= S_FETCH;
                     end else begin
                        note_code <= NOTE_REST;
                        song_done <= 1'b1;
                        state     <= S_DONE;
                     end
                  end else begin
                     note_code   <= word_code;
                     dur         <= (word_dur == '0) ? 10'd1 : word_dur;
                     ms_cnt      <= '0;
                     note_strobe <= 1'b1;
                     tone_en     <= (word_code != NOTE_REST);
                     led         <= (word_code != NOTE_REST) ? led_of(word_code) : '0;
                     state       <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (ms_tick) begin
                     if (ms_last) begin
                        rom.rom_addr <= rom.rom_addr + ADDR_W'(1);
                        tone_en      <= 1'b0;
                        led          <= '0;
                        ms_cnt       <= '0;
                        state        <= (GAP_MS > 0) ? S_GAP : S_FETCH;
                     end else begin
                        ms_cnt <= ms_cnt + 10'd1;
                     end
                  end
               end
               S_GAP: begin
                  if (ms_tick) begin
                     if (ms_last) begin
                        ms_cnt <= '0;
                        state  <= S_FETCH;
                     end else begin
                        ms_cnt <= ms_cnt + 10'd1;
                     end
                  end
               end
               S_DONE:  state <= S_DONE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
